pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register for the RISC-V core, the general replacement for the fixed inter-stage latches (EX/MEM first, then ID/EX and MEM/WB). It carries a control field and a data field across one stage with valid/ready handshaking, synchronous flush (bubble insertion), and a saturating stall-cycle counter. An optional two-entry skid mode registers the upstream ready so the ready path is cut at every stage boundary.

## Interface
- CTRL_W, 5, control-field width (EX/MEM: memtoreg, regwrite, memread, memwrite, memop)
- DATA_W, 69, data-field width (EX/MEM: alu_out 32 + rs2 32 + rd 5)
- CNT_W, 16, stall counter width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_ctrl  input  CTRL_W  upstream control field
- in_data  input  DATA_W  upstream data field
- flush  input  1  kill stage contents and the incoming beat
- out_valid  output  1  beat held for downstream
- out_ready  input  1  downstream consumes beat this cycle
- out_ctrl  output  CTRL_W  control field, forced to 0 when out_valid=0
- out_data  output  DATA_W  data field
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Accept: in_valid && in_ready at a rising edge. Consume: out_valid && out_ready.
- Reset (rst_n=0, async assert, sync release): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid entry empty.
- Control gating: out_ctrl = stored ctrl AND out_valid; downstream never sees regwrite/memwrite from an empty stage.
- Flush (highest priority, synchronous): next state empty (both entries in skid mode); beat presented that cycle dropped; in_ready=1 during flush so upstream advances; a simultaneous consume still completes this cycle. out_data keeps the old value (don't-care while out_valid=0).
- Stall (out_valid && !out_ready): held beat, out_ctrl and out_data stable; no overwrite.
- Ordering strictly FIFO; no beat duplicated or lost except by flush.
- stall_cnt: +1 each stalled cycle, saturates at 2^CNT_W-1, never wraps, cleared only by reset, not by flush.

## Timing
- Latency: 1 cycle, in_* at edge N -> out_* valid after edge N.
- Throughput: 1 beat/cycle when out_ready stays high.
- Without skid: in_ready = !out_valid || out_ready (combinational from out_ready); simultaneous accept+consume on a full stage replaces the beat.
- Skid mode: in_ready = !skid_valid, a registered output. Full main entry + out_ready=0 + accept -> beat to skid entry; next consume promotes skid to main in the same edge. in_ready returns 1 the cycle after the skid drains. Max two beats stored.
- No combinational path in_* -> out_* in either mode.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, registered in_ready as above.
- Undefined: single entry, combinational in_ready; area one register set.
- Ports, reset values, flush and counter behaviour are identical in both builds.

## Structure
- Package pipe_pkg: CTRL_W/DATA_W constants per stage, packed struct ex_mem_ctrl_t (memtoreg, regwrite, memread, memwrite, memop), ex_mem_data_t (alu_out, rs2, rd).
- Sub-module pipe_skid_entry: one valid+ctrl+data register with load/clear, instanced once (no skid) or twice (skid).
- stall counter lives in the top module.

## Test plan
- Reset mid-stream: assert rst_n=0 while out_valid=1, ctrl=5'h1F -> out_valid=0, out_ctrl=0, stall_cnt=0 immediately, without a clock edge.
- Streaming: 8 back-to-back beats data=0..7, out_ready=1 -> outputs 0..7 one cycle later, one per cycle, in_ready=1 throughout.
- Backpressure: out_ready=0 for 4 cycles with beat 0xA held -> out_data=0xA stable, stall_cnt=4; skid build: one more beat 0xB accepted then in_ready=0; release -> 0xA then 0xB.
- Flush: full stage with ctrl=5'b01010, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, incoming beat never appears.
- Flush with skid full: both entries occupied, flush=1 -> both killed, in_ready=1 next cycle.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15, stays 15 after flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and field layouts for the inter-stage pipeline
// registers of the RISC-V core. Each stage boundary has its own CTRL/DATA
// width pair, so one pipe_stage_reg can be instanced per boundary.
package pipe_pkg;

  // EX/MEM: memtoreg, regwrite, memread, memwrite, memop | alu_out, rs2, rd
  localparam int EX_MEM_CTRL_W = 5;
  localparam int EX_MEM_DATA_W = 69;

  // ID/EX: alusrc, aluop[1:0], regdst + the EX/MEM controls | pc, rs1, rs2, imm-side regs
  localparam int ID_EX_CTRL_W  = 9;
  localparam int ID_EX_DATA_W  = 111;

  // MEM/WB: memtoreg, regwrite | alu_out, mem_rdata, rd
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memop;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } ex_mem_data_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one storage slot of a pipeline stage (valid + ctrl + data).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_load             capture i_ctrl/i_data and mark the slot valid
//   i_clear            mark the slot empty (wins over i_load); payload kept
//   i_ctrl, i_data     payload to capture
//   o_valid, o_ctrl, o_data  stored slot contents
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int DATA_W = EX_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clearing only drops the valid bit: the payload is don't-care while empty
  // and leaving it alone saves enable fan-out on the wide data field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with flush and a
// saturating stall-cycle counter.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry skid buffer whose
// in_ready comes from a flop (cuts the ready path between stages); without it
// the stage is a single entry with in_ready combinational from out_ready.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid, in_ready              upstream handshake
//   in_ctrl, in_data                upstream payload
//   flush                           drop stage contents and the incoming beat
//   out_valid, out_ready            downstream handshake
//   out_ctrl                        stored ctrl, zero whenever out_valid=0
//   out_data                        stored data
//   stall_cnt                       saturating count of out_valid && !out_ready cycles
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_accept;
  logic              w_consume;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_in_ctrl;
  logic [DATA_W-1:0] w_main_in_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = w_main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  // Ready depends only on the skid flop (plus flush, which always lets
  // upstream advance since the presented beat is discarded anyway).
  assign in_ready = !w_skid_valid || flush;

  // A beat arriving while main is full and not draining parks in the skid slot.
  assign w_skid_load  = w_accept && !flush && w_main_valid && !out_ready;
  assign w_skid_clear = flush || w_consume;

  // Main refills from skid first (FIFO order), else straight from upstream.
  assign w_main_load  = !flush &&
                        ((w_consume && w_skid_valid) ||
                         (w_accept && (!w_main_valid || out_ready)));
  assign w_main_clear = flush || (w_consume && !w_skid_valid && !w_accept);

  assign w_main_in_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
  assign w_main_in_data = w_skid_valid ? w_skid_data : in_data;

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );
`else
  // A full stage can still take a beat when the held one leaves this cycle.
  assign in_ready = !w_main_valid || out_ready || flush;

  assign w_main_load    = w_accept && !flush;
  assign w_main_clear   = flush || (w_consume && !w_accept);
  assign w_main_in_ctrl = in_ctrl;
  assign w_main_in_data = in_data;
`endif

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_in_ctrl),
    .i_data  (w_main_in_data),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  // Saturating; flush does not clear it so stall history survives bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = w_main_valid;
  // Gate ctrl so an empty stage never asserts regwrite/memwrite downstream.
  assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign out_data  = w_main_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 5;
  localparam int DW = 69;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          rdy;
    logic          fl;
    logic          e_valid;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [CW-1:0] sat_out_ctrl;
  logic [DW-1:0] sat_out_data;
  logic [3:0]    sat_stall_cnt;

  int n_checks;
  int n_errors;

  // reference model: stored beats in arrival order plus stall counters
  beat_t       mq[$];
  int unsigned m_cnt16;
  int unsigned m_cnt4;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (sat_out_ctrl),
    .out_data  (sat_out_data),
    .stall_cnt (sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic          ev;
    logic [CW-1:0] ec;
    ev = (mq.size() > 0);
    ec = ev ? mq[0].c : '0;
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_ctrl", 128'(out_ctrl), 128'(ec));
    if (ev) begin
      chk("out_data", 128'(out_data), 128'(mq[0].d));
      chk("sat_out_data", 128'(sat_out_data), 128'(mq[0].d));
    end
    chk("sat_out_valid", 128'(sat_out_valid), 128'(ev));
    chk("sat_out_ctrl", 128'(sat_out_ctrl), 128'(ec));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt16));
    chk("sat_stall_cnt", 128'(sat_stall_cnt), 128'(m_cnt4));
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic do_cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                          input logic rdy, input logic fl);
    logic exp_rdy;
    logic stall;
    logic cons;
    logic acc;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = (mq.size() < 2) || fl;
`else
    exp_rdy = (mq.size() == 0) || rdy || fl;
`endif
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("sat_in_ready", 128'(sat_in_ready), 128'(exp_rdy));
    stall = (mq.size() > 0) && !rdy;
    cons  = (mq.size() > 0) && rdy;
    acc   = v && exp_rdy;
    if (fl) begin
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back({c, d});
    end
    if (stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt16 = 0;
    m_cnt4  = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    chk("rst_out_data", 128'(out_data), 128'(0));
  endtask

  vec_t        tbl[12];
  logic [95:0] r96;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    model_clear();

    // table: streaming 0..7, then a stalled beat flushed with a live input
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b1, CW'(i), DW'(i)};
    end
    tbl[8]  = '{1'b1, 5'b01010, DW'('h55), 1'b1, 1'b0, 1'b1, 5'b01010, DW'('h55)};
    tbl[9]  = '{1'b0, 5'h00,    DW'(0),    1'b0, 1'b0, 1'b1, 5'b01010, DW'('h55)};
    tbl[10] = '{1'b1, 5'h1F,    DW'('h66), 1'b0, 1'b1, 1'b0, 5'h00,    DW'(0)};
    tbl[11] = '{1'b0, 5'h00,    DW'(0),    1'b1, 1'b0, 1'b0, 5'h00,    DW'(0)};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_cycle(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl_valid[%0d]", i), 128'(out_valid), 128'(tbl[i].e_valid));
      chk($sformatf("tbl_ctrl[%0d]", i), 128'(out_ctrl), 128'(tbl[i].e_ctrl));
      if (tbl[i].e_valid)
        chk($sformatf("tbl_data[%0d]", i), 128'(out_data), 128'(tbl[i].e_data));
    end

    // reset mid-stream, observed without a clock edge
    do_reset();
    do_cycle(1'b1, 5'h1F, DW'('h123), 1'b0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("mid_ctrl_before", 128'(out_ctrl), 128'(5'h1F));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_ctrl", 128'(out_ctrl), 128'(0));
    chk("mid_rst_cnt", 128'(stall_cnt), 128'(0));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // backpressure
    do_reset();
    do_cycle(1'b1, 5'h03, DW'('hA), 1'b0, 1'b0);
    repeat (4) do_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_data", 128'(out_data), 128'('hA));
    chk("bp_cnt", 128'(stall_cnt), 128'(4));
    do_cycle(1'b1, 5'h04, DW'('hB), 1'b0, 1'b0);
    chk("bp_data_held", 128'(out_data), 128'('hA));
    #1;
    chk("bp_ready_low", 128'(in_ready), 128'(0));
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_second_valid", 128'(out_valid), 128'(1));
    chk("bp_second_data", 128'(out_data), 128'('hB));
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0);
`endif
    chk("bp_drained", 128'(out_valid), 128'(0));

    // flush with both entries occupied (second beat refused without skid)
    do_reset();
    do_cycle(1'b1, 5'h01, DW'('h11), 1'b0, 1'b0);
    do_cycle(1'b1, 5'h02, DW'('h22), 1'b0, 1'b0);
    do_cycle(1'b1, 5'h03, DW'('h33), 1'b0, 1'b1);
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("fl_ready_after", 128'(in_ready), 128'(1));
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // saturation of the 4-bit counter, surviving a flush
    do_reset();
    do_cycle(1'b1, 5'h1F, DW'(7), 1'b0, 1'b0);
    repeat (20) do_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_cnt4", 128'(sat_stall_cnt), 128'(15));
    chk("sat_cnt16", 128'(stall_cnt), 128'(20));
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("sat_cnt4_post_flush", 128'(sat_stall_cnt), 128'(15));
    chk("sat_cnt16_post_flush", 128'(stall_cnt), 128'(21));

    // randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      do_cycle(($urandom_range(0, 9) < 7), CW'($urandom()), r96[DW-1:0],
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
